// File: rtl/stopwatch_core_pkg.sv
// Shared definitions for the MM:SS stopwatch: FSM encodings, BCD digit
// limits and a helper that validates a packed {tens, units} BCD pair.
package stopwatch_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } sw_state_e;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] UNITS_MAX    = 4'd9;

  // A minutes or seconds field is legal when tens <= 5 and units <= 9.
  function automatic logic bcd_pair_ok(input logic [7:0] v);
    return (v[7:4] <= SEC_TENS_MAX) && (v[3:0] <= UNITS_MAX);
  endfunction

endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// One BCD digit counting modulo MAX+1, with synchronous clear/load,
// enable, up/down direction and a combinational carry/borrow out that
// enables the next digit in the chain.
module bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  input  logic       down_i,
  output logic [3:0] digit_o,
  output logic       co_o
);

  logic [3:0] digit_q;
  logic [3:0] digit_d;

  // Carry when stepping up past MAX, borrow when stepping down past 0.
  always_comb begin
    co_o = en_i & (down_i ? (digit_q == 4'd0) : (digit_q == MAX));
  end

  // Next digit value: clear beats load beats counting.
  always_comb begin
    digit_d = digit_q;
    if (clr_i) begin
      digit_d = 4'd0;
    end else if (load_i) begin
      digit_d = load_val_i;
    end else if (en_i) begin
      if (down_i) begin
        digit_d = (digit_q == 4'd0) ? MAX : digit_q - 4'd1;
      end else begin
        digit_d = (digit_q == MAX) ? 4'd0 : digit_q + 4'd1;
      end
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch. The slow tick is sampled as data through a
// synchroniser and an edge detector; each rising edge becomes a one-clk
// step that advances the count while the FSM is in RUN.
// Control handshake: start_stop, clear and load are one-clk pulses with no
// ready/acknowledge; each is acted on in the cycle it is high and never
// queued. Same-cycle priority is clear > load > start_stop > step.
// state_dbg mirrors the FSM state register for observation.
module stopwatch_core
  import stopwatch_defs::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       load,
  input  logic       dir,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       wrap,
  output logic       done,
  output logic [1:0] state_dbg
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   step;

  sw_state_e state_q, state_d;
  logic      running_q, wrap_q, done_q;

  logic [3:0] su, st, mu, mt;
  logic       co_su, co_st, co_mu, co_mt;

  logic count_zero, count_one, count_max;
  logic preset_ok, load_take, ss_take, step_take;
  logic cnt_en, hit_done, hit_wrap;

  // Synchroniser chain plus edge flop on the slow tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign step = sync_q[SYNC_STAGES-1] & ~edge_q;

  // Count decode, preset validation and the priority chain.
  always_comb begin
    count_zero = ({mt, mu, st, su} == 16'h0000);
    count_one  = ({mt, mu, st, su} == 16'h0001);
    count_max  = ({mt, mu, st, su} == 16'h5959);
    preset_ok  = bcd_pair_ok(preset_min) & bcd_pair_ok(preset_sec);
    load_take  = load & preset_ok & ~clear;
    ss_take    = start_stop & ~clear & ~load_take;
    step_take  = step & (state_q == ST_RUN) & ~clear & ~load_take & ~start_stop;
    // A down step from 00:00 ends the run without wrapping the count.
    cnt_en     = step_take & ~(dir & count_zero);
    hit_done   = step_take & dir & (count_zero | count_one);
    hit_wrap   = step_take & ~dir & count_max;
  end

  // Next FSM state.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (load_take) begin
      if (state_q == ST_DONE) state_d = ST_IDLE;
    end else if (ss_take) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_DONE;
      endcase
    end else if (hit_done) begin
      state_d = ST_DONE;
    end
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == ST_RUN);
      wrap_q    <= hit_wrap;
      done_q    <= hit_done;
    end
  end

  bcd_digit #(.MAX(UNITS_MAX)) u_sec_units (
    .clk(clk), .rst_n(rst_n), .clr_i(clear), .load_i(load_take),
    .load_val_i(preset_sec[3:0]), .en_i(cnt_en), .down_i(dir),
    .digit_o(su), .co_o(co_su)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst_n(rst_n), .clr_i(clear), .load_i(load_take),
    .load_val_i(preset_sec[7:4]), .en_i(co_su), .down_i(dir),
    .digit_o(st), .co_o(co_st)
  );

  bcd_digit #(.MAX(UNITS_MAX)) u_min_units (
    .clk(clk), .rst_n(rst_n), .clr_i(clear), .load_i(load_take),
    .load_val_i(preset_min[3:0]), .en_i(co_st), .down_i(dir),
    .digit_o(mu), .co_o(co_mu)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_min_tens (
    .clk(clk), .rst_n(rst_n), .clr_i(clear), .load_i(load_take),
    .load_val_i(preset_min[7:4]), .en_i(co_mu), .down_i(dir),
    .digit_o(mt), .co_o(co_mt)
  );

  // The top digit's carry is covered by the 59:59 decode; it only closes the chain.
  logic unused_co;
  assign unused_co = co_mt;

  assign min_bcd   = {mt, mu};
  assign sec_bcd   = {st, su};
  assign running   = running_q;
  assign wrap      = wrap_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with a seconds-based reference model
// compared against the outputs on every cycle out of reset.
module tb_stopwatch_core;

  localparam int SYNC = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       load = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] preset_min = 8'h00;
  logic [7:0] preset_sec = 8'h00;
  logic [7:0] min_bcd, sec_bcd;
  logic       running, wrap, done;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Reference model state: count in plain seconds, run state, pulses.
  int            m_secs = 0;
  int            m_st   = M_IDLE;
  bit            m_wrap = 1'b0;
  bit            m_done = 1'b0;
  logic [SYNC:0] hist   = '0;

  stopwatch_core #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .start_stop(start_stop),
    .clear(clear), .load(load), .dir(dir), .preset_min(preset_min),
    .preset_sec(preset_sec), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .running(running), .wrap(wrap), .done(done), .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic bit field_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  function automatic int field_val(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a tick rising edge counts SYNC+1 clock edges after it is sampled.
  always @(posedge clk or negedge rst_n) begin : model
    int s, stv;
    bit w, d, stp;
    if (!rst_n) begin
      m_secs <= 0; m_st <= M_IDLE; m_wrap <= 1'b0; m_done <= 1'b0; hist <= '0;
    end else begin
      s = m_secs; stv = m_st; w = 1'b0; d = 1'b0;
      stp = hist[SYNC-1] && !hist[SYNC];
      if (clear) begin
        s = 0; stv = M_IDLE;
      end else if (load && field_ok(preset_min) && field_ok(preset_sec)) begin
        s = field_val(preset_min) * 60 + field_val(preset_sec);
        if (stv == M_DONE) stv = M_IDLE;
      end else if (start_stop) begin
        if (stv == M_IDLE || stv == M_PAUSE) stv = M_RUN;
        else if (stv == M_RUN) stv = M_PAUSE;
      end else if (stp && stv == M_RUN) begin
        if (!dir) begin
          if (s == 3599) begin s = 0; w = 1'b1; end
          else s = s + 1;
        end else begin
          if (s <= 1) begin s = 0; d = 1'b1; stv = M_DONE; end
          else s = s - 1;
        end
      end
      m_secs <= s; m_st <= stv; m_wrap <= w; m_done <= d;
      hist <= {hist[SYNC-1:0], tick_in};
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      check("model_min", min_bcd, to_bcd(m_secs / 60));
      check("model_sec", sec_bcd, to_bcd(m_secs % 60));
      check("model_running", {7'd0, running}, {7'd0, m_st == M_RUN});
      check("model_wrap", {7'd0, wrap}, {7'd0, m_wrap});
      check("model_done", {7'd0, done}, {7'd0, m_done});
    end
  end

  // Driver tasks: everything changes on the falling edge.
  task automatic pulse(input logic c, input logic l, input logic s);
    @(negedge clk);
    clear = c; load = l; start_stop = s;
    @(negedge clk);
    clear = 1'b0; load = 1'b0; start_stop = 1'b0;
  endtask

  task automatic load_preset(input logic [7:0] mn, input logic [7:0] sc);
    preset_min = mn; preset_sec = sc;
    pulse(1'b0, 1'b1, 1'b0);
  endtask

  task automatic tick_rise();
    @(negedge clk);
    tick_in = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
  endtask

  task automatic tick_fall();
    tick_in = 1'b0;
    repeat (SYNC + 1) @(negedge clk);
  endtask

  task automatic tick();
    tick_rise();
    tick_fall();
  endtask

  task automatic check_time(input string name, input logic [7:0] mn, input logic [7:0] sc, input logic run);
    check({name, "_min"}, min_bcd, mn);
    check({name, "_sec"}, sec_bcd, sc);
    check({name, "_running"}, {7'd0, running}, {7'd0, run});
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    check_time("reset", 8'h00, 8'h00, 1'b0);
    check("reset_wrap", {7'd0, wrap}, 8'h00);
    check("reset_done", {7'd0, done}, 8'h00);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // 1: five up ticks, latency pinned on the first
    dir = 1'b0;
    pulse(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    tick_in = 1'b1;
    @(negedge clk); check("lat_edge1", sec_bcd, 8'h00);
    @(negedge clk); check("lat_edge2", sec_bcd, 8'h00);
    @(negedge clk); check("lat_edge3", sec_bcd, 8'h01);
    tick_fall();
    repeat (4) tick();
    check_time("t1", 8'h00, 8'h05, 1'b1);

    // 2: rollover 59:59 -> 00:00
    pulse(1'b1, 1'b0, 1'b0);
    load_preset(8'h59, 8'h58);
    pulse(1'b0, 1'b0, 1'b1);
    tick();
    check_time("t2a", 8'h59, 8'h59, 1'b1);
    tick_rise();
    check_time("t2b", 8'h00, 8'h00, 1'b1);
    check("t2_wrap_hi", {7'd0, wrap}, 8'h01);
    @(negedge clk);
    check("t2_wrap_lo", {7'd0, wrap}, 8'h00);
    tick_fall();

    // 3: count down from 01:00 to expiry
    pulse(1'b1, 1'b0, 1'b0);
    load_preset(8'h01, 8'h00);
    dir = 1'b1;
    pulse(1'b0, 1'b0, 1'b1);
    tick();
    check_time("t3a", 8'h00, 8'h59, 1'b1);
    for (int i = 0; i < 58; i++) tick();
    check_time("t3b", 8'h00, 8'h01, 1'b1);
    tick_rise();
    check_time("t3c", 8'h00, 8'h00, 1'b0);
    check("t3_done_hi", {7'd0, done}, 8'h01);
    @(negedge clk);
    check("t3_done_lo", {7'd0, done}, 8'h00);
    tick_fall();
    tick();
    check_time("t3d", 8'h00, 8'h00, 1'b0);

    // 4: pause holds the count
    pulse(1'b1, 1'b0, 1'b0);
    load_preset(8'h00, 8'h10);
    dir = 1'b0;
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    check_time("t4a", 8'h00, 8'h10, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    tick();
    check_time("t4b", 8'h00, 8'h11, 1'b1);

    // 5: clear wins over load and start_stop; invalid preset is ignored
    preset_min = 8'h12; preset_sec = 8'h34;
    pulse(1'b1, 1'b1, 1'b1);
    check_time("t5a", 8'h00, 8'h00, 1'b0);
    load_preset(8'h00, 8'h20);
    check_time("t5b", 8'h00, 8'h20, 1'b0);
    load_preset(8'h00, 8'h6A);
    check_time("t5c", 8'h00, 8'h20, 1'b0);
    load_preset(8'h60, 8'h00);
    check_time("t5d", 8'h00, 8'h20, 1'b0);

    // Down-count entered at 00:00 expires on the first step
    pulse(1'b1, 1'b0, 1'b0);
    dir = 1'b1;
    pulse(1'b0, 1'b0, 1'b1);
    tick_rise();
    check_time("zero_down", 8'h00, 8'h00, 1'b0);
    check("zero_down_done", {7'd0, done}, 8'h01);
    tick_fall();
    load_preset(8'h00, 8'h05);
    check_time("done_load", 8'h00, 8'h05, 1'b0);

    // 6: asynchronous reset mid-count
    pulse(1'b1, 1'b0, 1'b0);
    load_preset(8'h12, 8'h34);
    dir = 1'b0;
    pulse(1'b0, 1'b0, 1'b1);
    check_time("t6a", 8'h12, 8'h34, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_time("t6_async", 8'h00, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_time("t6b", 8'h00, 8'h00, 1'b0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
